// File: rtl/register_bank_pkg.sv
// register_bank_pkg: shared FSM state type and default sizing for the register bank.
//   Exports state_t (IDLE, CLEAR) and DEF_LANES/DEF_REGS/DEF_WIDTH/DEF_RPORTS.
package register_bank_pkg;
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam int DEF_LANES  = 8;
    localparam int DEF_REGS   = 32;
    localparam int DEF_WIDTH  = 64;
    localparam int DEF_RPORTS = 2;
endpackage

// File: rtl/register_lane.sv
// register_lane: one SIMD lane of REGS x WIDTH storage with one write port and RPORTS registered read ports.
//   clk, rst    : clock, asynchronous active-high reset (clears read data only)
//   we/waddr/wdata : write port; out-of-range addresses are dropped
//   re/raddr    : per-port read enable and address
//   rdata       : per-port registered read data, held when re is low, write-first bypass
module register_lane
    import register_bank_pkg::*;
#(
    parameter int REGS   = DEF_REGS,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int RPORTS = DEF_RPORTS,
    localparam int AW    = $clog2(REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [AW-1:0]                  waddr,
    input  logic [WIDTH-1:0]               wdata,
    input  logic [RPORTS-1:0]              re,
    input  logic [RPORTS-1:0][AW-1:0]      raddr,
    output logic [RPORTS-1:0][WIDTH-1:0]   rdata
);
    logic [WIDTH-1:0] mem [REGS];
    logic w_ok;

    assign w_ok = we && (32'(waddr) < 32'(REGS));

    // Storage deliberately has no reset; the top-level sweep zeroes it.
    always_ff @(posedge clk)
        if (w_ok) mem[waddr] <= wdata;

    always_ff @(posedge clk or posedge rst)
        if (rst) rdata <= '0;
        else
            for (int p = 0; p < RPORTS; p++)
                if (re[p])
                    rdata[p] <= (32'(raddr[p]) >= 32'(REGS)) ? '0 :
                                (w_ok && waddr == raddr[p]) ? wdata : mem[raddr[p]];
endmodule

// File: rtl/register_bank_mp.sv
// register_bank_mp: multi-port SIMD register bank with a clear sweep after reset or on request.
//   clk, rst  : clock, asynchronous active-high reset (starts a sweep on release)
//   write_en/waddr/wdata : per-lane write, shared address
//   read_en/raddr        : per-port per-lane read enable, per-port address
//   rdata/rvalid         : registered read data and per-port valid
//   clear_req/busy       : request a zeroing sweep / sweep in progress
module register_bank_mp
    import register_bank_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int REGS   = DEF_REGS,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int RPORTS = DEF_RPORTS,
    localparam int AW    = $clog2(REGS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [LANES-1:0]                       write_en,
    input  logic [AW-1:0]                          waddr,
    input  logic [LANES-1:0][WIDTH-1:0]            wdata,
    input  logic [RPORTS-1:0][LANES-1:0]           read_en,
    input  logic [RPORTS-1:0][AW-1:0]              raddr,
    output logic [RPORTS-1:0][LANES-1:0][WIDTH-1:0] rdata,
    output logic [RPORTS-1:0]                      rvalid,
    input  logic                                   clear_req,
    output logic                                   busy
);
    state_t                               state;
    logic [AW-1:0]                        cnt;
    logic [LANES-1:0]                     lane_we;
    logic [AW-1:0]                        lane_waddr;
    logic [LANES-1:0][WIDTH-1:0]          lane_wdata;
    logic [LANES-1:0][RPORTS-1:0]         lane_re;
    logic [LANES-1:0][RPORTS-1:0][WIDTH-1:0] lane_rd;

    // busy mirrors state as its own flop so the output is registered.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy   <= 1'b1;
            rvalid <= '0;
        end else begin
            for (int p = 0; p < RPORTS; p++)
                rvalid[p] <= |read_en[p] && !busy;
            if (state == IDLE) begin
                if (clear_req) begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                    cnt   <= '0;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == AW'(REGS-1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            end
        end

    // During the sweep the lane write ports zero row cnt; a clear request discards a coincident write.
    always_comb begin
        lane_waddr = busy ? cnt : waddr;
        for (int l = 0; l < LANES; l++) begin
            lane_we[l]    = busy | (write_en[l] & ~clear_req);
            lane_wdata[l] = busy ? '0 : wdata[l];
            for (int p = 0; p < RPORTS; p++)
                lane_re[l][p] = read_en[p][l] & ~busy;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        register_lane #(.REGS(REGS), .WIDTH(WIDTH), .RPORTS(RPORTS)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we    (lane_we[l]),
            .waddr (lane_waddr),
            .wdata (lane_wdata[l]),
            .re    (lane_re[l]),
            .raddr (raddr),
            .rdata (lane_rd[l])
        );
        for (genvar p = 0; p < RPORTS; p++) begin : g_port
            assign rdata[p][l] = lane_rd[l][p];
        end
    end
endmodule

// File: tb/tb_register_bank_mp.sv
// tb_register_bank_mp: scoreboard bench for register_bank_mp with a behavioural model of the bank.
module tb_register_bank_mp;
    localparam int L  = 8;
    localparam int R  = 32;
    localparam int W  = 64;
    localparam int P  = 2;
    localparam int AW = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [L-1:0]            write_en;
    logic [AW-1:0]           waddr;
    logic [L-1:0][W-1:0]     wdata;
    logic [P-1:0][L-1:0]     read_en;
    logic [P-1:0][AW-1:0]    raddr;
    logic [P-1:0][L-1:0][W-1:0] rdata;
    logic [P-1:0]            rvalid;
    logic                    clear_req;
    logic                    busy;

    always #5 clk = ~clk;

    register_bank_mp #(.LANES(L), .REGS(R), .WIDTH(W), .RPORTS(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .write_en  (write_en),
        .waddr     (waddr),
        .wdata     (wdata),
        .read_en   (read_en),
        .raddr     (raddr),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .clear_req (clear_req),
        .busy      (busy)
    );

    typedef struct {
        int           kind;
        int           p;
        int           l;
        logic [W-1:0] exp;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] m_mem [R][L];
    logic [W-1:0] m_rd  [P][L];
    logic [P-1:0] m_rv;
    bit           m_busy;
    int           m_cnt;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic idle_in();
        write_en  = '0;
        waddr     = '0;
        wdata     = '0;
        read_en   = '0;
        raddr     = '0;
        clear_req = 1'b0;
    endtask

    task automatic rand_in(input bit allow_clear);
        write_en = L'($urandom());
        waddr    = AW'($urandom_range(0, R-1));
        for (int l = 0; l < L; l++) wdata[l] = {$urandom(), $urandom()};
        for (int p = 0; p < P; p++) begin
            read_en[p] = L'($urandom());
            raddr[p]   = AW'($urandom_range(0, R-1));
        end
        clear_req = allow_clear && ($urandom_range(0, 39) == 0);
    endtask

    // Predict the effect of the current inputs, clock once, then compare every queued expectation.
    task automatic step();
        exp_t         e;
        logic [W-1:0] act;
        string        tag;
        if (!m_busy) begin
            for (int p = 0; p < P; p++) begin
                m_rv[p] = |read_en[p];
                for (int l = 0; l < L; l++)
                    if (read_en[p][l])
                        m_rd[p][l] = (write_en[l] && !clear_req && waddr == raddr[p]) ? wdata[l] : m_mem[raddr[p]][l];
            end
            if (clear_req) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end else
                for (int l = 0; l < L; l++)
                    if (write_en[l]) m_mem[waddr][l] = wdata[l];
        end else begin
            m_rv = '0;
            for (int l = 0; l < L; l++) m_mem[m_cnt][l] = '0;
            m_busy = (m_cnt != R-1);
            m_cnt  = (m_cnt + 1) % R;
        end
        sb.push_back('{2, 0, 0, W'(m_busy)});
        for (int p = 0; p < P; p++) begin
            sb.push_back('{1, p, 0, W'(m_rv[p])});
            for (int l = 0; l < L; l++) sb.push_back('{0, p, l, m_rd[p][l]});
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == 0) begin
                act = rdata[e.p][e.l];
                tag = $sformatf("rdata[%0d][%0d]", e.p, e.l);
            end else if (e.kind == 1) begin
                act = W'(rvalid[e.p]);
                tag = $sformatf("rvalid[%0d]", e.p);
            end else begin
                act = W'(busy);
                tag = "busy";
            end
            check(tag, act, e.exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        for (int p = 0; p < P; p++)
            for (int l = 0; l < L; l++) m_rd[p][l] = '0;
        m_rv   = '0;
        m_busy = 1'b1;
        m_cnt  = 0;
        check("rst_busy", W'(busy), W'(1));
        check("rst_rvalid", W'(rvalid), W'(0));
        for (int p = 0; p < P; p++)
            for (int l = 0; l < L; l++) check($sformatf("rst_rdata[%0d][%0d]", p, l), rdata[p][l], '0);
        repeat (n) @(posedge clk);
        #1;
        check("rst_busy_hold", W'(busy), W'(1));
        rst = 1'b0;
    endtask

    // Count cycles until busy drops, bounded so a stuck sweep still reaches the summary.
    task automatic run_sweep(input bit traffic);
        int n = 0;
        while (busy && n < 100) begin
            if (traffic) rand_in(1'b1);
            else idle_in();
            step();
            n++;
        end
        idle_in();
        check("busy_len", W'(n), W'(R));
    endtask

    task automatic fill_all();
        for (int a = 0; a < R; a++) begin
            idle_in();
            write_en = '1;
            waddr    = AW'(a);
            for (int l = 0; l < L; l++) wdata[l] = {$urandom(), $urandom()};
            step();
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < R; a++) begin
            idle_in();
            read_en  = '1;
            raddr[0] = AW'(a);
            raddr[1] = AW'(R-1-a);
            step();
        end
    endtask

    initial begin
        for (int a = 0; a < R; a++)
            for (int l = 0; l < L; l++) m_mem[a][l] = '0;
        idle_in();
        do_reset(3);
        run_sweep(1'b0);
        repeat (8) begin
            idle_in();
            step();
        end
        read_all();

        idle_in();
        write_en = '1;
        waddr    = 5;
        for (int l = 0; l < L; l++) wdata[l] = 64'hA5A5_0000_0000_0000 | 64'(l);
        step();
        idle_in();
        read_en[0] = '1;
        raddr[0]   = 5;
        step();
        idle_in();
        step();

        idle_in();
        write_en = '1;
        waddr    = 3;
        for (int l = 0; l < L; l++) wdata[l] = 64'h11;
        step();
        idle_in();
        write_en = 8'h0F;
        waddr    = 3;
        for (int l = 0; l < L; l++) wdata[l] = 64'h2200 + 64'(l);
        step();
        idle_in();
        read_en  = '1;
        raddr[0] = 3;
        raddr[1] = 3;
        step();

        idle_in();
        write_en   = '1;
        waddr      = 7;
        for (int l = 0; l < L; l++) wdata[l] = 64'hDEAD;
        read_en[0] = '1;
        read_en[1] = 8'hF0;
        raddr[0]   = 7;
        raddr[1]   = 7;
        step();

        fill_all();
        read_all();
        idle_in();
        clear_req = 1'b1;
        write_en  = '1;
        waddr     = 0;
        for (int l = 0; l < L; l++) wdata[l] = {$urandom(), $urandom()};
        read_en   = '1;
        raddr[0]  = 0;
        raddr[1]  = 9;
        step();
        run_sweep(1'b1);
        read_all();

        fill_all();
        idle_in();
        clear_req = 1'b1;
        step();
        repeat (10) begin
            idle_in();
            step();
        end
        do_reset(2);
        run_sweep(1'b0);
        read_all();

        repeat (300) begin
            rand_in(1'b1);
            step();
        end
        idle_in();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
